// File: rtl/id_imm_ctrl_if.sv
// ---------------------------------------------------------------------------
// id_imm_ctrl_if
// Bundles the fetch->decode handshake, the decode<->immediate-extender link
// and the decode->execute handshake of the immediate-control stage.
//   InstrF/ValidF/ReadyD : instruction offer from fetch and its accept
//   FlushD               : redirect, discards decode contents
//   InstrD/ImmSrcD/SE    : registered word and format select to the extender,
//                          extended immediate back from it
//   ValidE/ReadyE        : execute-stage handshake
//   ImmExtE/ImmUsedE/IllegalE/IllegalCount : execute-stage results
// slave  : the id_imm_ctrl block
// master : the surrounding pipeline (fetch, extender, execute)
// ---------------------------------------------------------------------------
interface id_imm_ctrl_if;
  logic [31:0] InstrF;
  logic        ValidF;
  logic        ReadyD;
  logic        FlushD;
  logic [31:0] InstrD;
  logic [2:0]  ImmSrcD;
  logic [31:0] SE;
  logic        ReadyE;
  logic        ValidE;
  logic [31:0] ImmExtE;
  logic        ImmUsedE;
  logic        IllegalE;
  logic [7:0]  IllegalCount;

  modport slave (
    input  InstrF, ValidF, FlushD, SE, ReadyE,
    output ReadyD, InstrD, ImmSrcD, ValidE, ImmExtE, ImmUsedE, IllegalE,
           IllegalCount
  );

  modport master (
    output InstrF, ValidF, FlushD, SE, ReadyE,
    input  ReadyD, InstrD, ImmSrcD, ValidE, ImmExtE, ImmUsedE, IllegalE,
           IllegalCount
  );
endinterface

// File: rtl/id_imm_ctrl.sv
// ---------------------------------------------------------------------------
// id_imm_ctrl
// Two-register (decode, execute) elastic stage that holds an instruction,
// selects the immediate format for an external combinational extender,
// and captures the extended immediate plus used/illegal flags for execute.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : id_imm_ctrl_if.slave (fetch offer, flush, extender link,
//          execute handshake and results, saturating illegal counter)
// ---------------------------------------------------------------------------
module id_imm_ctrl (
  input  logic            clk,
  input  logic            rst,
  id_imm_ctrl_if.slave    bus
);

  // Opcode decode: returns {imm_src[2:0], imm_used, illegal}.
  // R-type is legal but carries no immediate.
  function automatic logic [4:0] decode_op(input logic [6:0] op);
    logic [4:0] res;
    case (op)
      7'b0000011,
      7'b0010011,
      7'b1100111: res = {3'b000, 1'b1, 1'b0};
      7'b0100011: res = {3'b001, 1'b1, 1'b0};
      7'b1101111: res = {3'b010, 1'b1, 1'b0};
      7'b1100011: res = {3'b011, 1'b1, 1'b0};
      7'b0110111,
      7'b0010111: res = {3'b100, 1'b1, 1'b0};
      7'b0110011: res = {3'b000, 1'b0, 1'b0};
      default:    res = {3'b000, 1'b0, 1'b1};
    endcase
    return res;
  endfunction

  logic        valid_d_r;
  logic [31:0] instr_d_r;
  logic        valid_e_r;
  logic [31:0] imm_ext_e_r;
  logic        imm_used_e_r;
  logic        illegal_e_r;
  logic [7:0]  illegal_cnt_r;

  logic        adv_e_s;
  logic        ready_d_s;
  logic [2:0]  imm_src_s;
  logic        imm_used_s;
  logic        illegal_s;

  // Handshake: execute advances when empty or drained; decode accepts when
  // empty or advancing. Held ready during reset so fetch never sees a stall.
  always_comb begin
    adv_e_s   = !valid_e_r || bus.ReadyE;
    ready_d_s = rst || !valid_d_r || adv_e_s;
  end

  // Immediate format and flags of the decode-stage word; all zero when the
  // decode register is empty (or in reset) so nothing stale leaks forward.
  always_comb begin
    logic [4:0] dec_v;
    dec_v      = decode_op(instr_d_r[6:0]);
    imm_src_s  = 3'b000;
    imm_used_s = 1'b0;
    illegal_s  = 1'b0;
    if (!rst && valid_d_r) begin
      imm_src_s  = dec_v[4:2];
      imm_used_s = dec_v[1];
      illegal_s  = dec_v[0];
    end else begin
      imm_src_s  = 3'b000;
      imm_used_s = 1'b0;
      illegal_s  = 1'b0;
    end
  end

  // Decode register: a flush wins over a same-cycle accept (the offered
  // word is consumed but dropped); execute state is untouched by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_d_r <= 1'b0;
      instr_d_r <= 32'h0000_0000;
    end else if (bus.FlushD) begin
      valid_d_r <= 1'b0;
    end else if (ready_d_s) begin
      if (bus.ValidF) begin
        valid_d_r <= 1'b1;
        instr_d_r <= bus.InstrF;
      end else begin
        valid_d_r <= 1'b0;
      end
    end
  end

  // Execute register: captures decode state and the extender result on
  // advance, otherwise holds stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_e_r    <= 1'b0;
      imm_ext_e_r  <= 32'h0000_0000;
      imm_used_e_r <= 1'b0;
      illegal_e_r  <= 1'b0;
    end else if (adv_e_s) begin
      valid_e_r    <= valid_d_r;
      imm_ext_e_r  <= bus.SE;
      imm_used_e_r <= imm_used_s;
      illegal_e_r  <= illegal_s;
    end
  end

  // Saturating count of illegal instructions entering execute.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_cnt_r <= 8'd0;
    end else if (adv_e_s && valid_d_r && illegal_s && (illegal_cnt_r != 8'd255)) begin
      illegal_cnt_r <= illegal_cnt_r + 8'd1;
    end
  end

  assign bus.ReadyD       = ready_d_s;
  assign bus.InstrD       = instr_d_r;
  assign bus.ImmSrcD      = imm_src_s;
  assign bus.ValidE       = valid_e_r;
  assign bus.ImmExtE      = imm_ext_e_r;
  assign bus.ImmUsedE     = imm_used_e_r;
  assign bus.IllegalE     = illegal_e_r;
  assign bus.IllegalCount = illegal_cnt_r;

endmodule

// File: tb/tb_id_imm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_id_imm_ctrl
// Directed stimulus with a scoreboard: each accepted instruction pushes its
// hand-computed execute-stage result; a negedge monitor pops and compares
// whenever ValidE && ReadyE. Includes a model of the external extender.
// ---------------------------------------------------------------------------
module tb_id_imm_ctrl;

  logic clk;
  logic rst;
  id_imm_ctrl_if bus();

  id_imm_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External immediate extender model.
  logic [31:0] se_model;
  always_comb begin
    logic [31:0] i;
    i = bus.InstrD;
    case (bus.ImmSrcD)
      3'b000:  se_model = {{20{i[31]}}, i[31:20]};
      3'b001:  se_model = {{20{i[31]}}, i[31:25], i[11:7]};
      3'b010:  se_model = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      3'b011:  se_model = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      3'b100:  se_model = {i[31:12], 12'h000};
      default: se_model = 32'h0000_0000;
    endcase
  end
  assign bus.SE = se_model;

  typedef struct {
    logic [31:0] imm;
    logic        used;
    logic        ill;
    bit          lat;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: compare each execute-stage transfer against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ValidE && bus.ReadyE) begin
        if (sbq.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected: ValidE with ImmExtE=0x%08h, expected no output", bus.ImmExtE);
        end else begin
          mon_e = sbq.pop_front();
          chk("ImmExtE", bus.ImmExtE, mon_e.imm);
          chk("ImmUsedE", {31'd0, bus.ImmUsedE}, {31'd0, mon_e.used});
          chk("IllegalE", {31'd0, bus.IllegalE}, {31'd0, mon_e.ill});
          if (mon_e.lat) chk("latency_cycle", cyc, mon_e.acc + 1);
        end
      end else if (!bus.ValidE) begin
        chk("idle_flags", {30'd0, bus.ImmUsedE, bus.IllegalE}, 32'd0);
      end
    end
  end

  // Offer one instruction (called #1 after a posedge); wait for the accept
  // edge, push the expected result and check ImmSrcD of the new decode word.
  task automatic send(input logic [31:0] instr, input logic [2:0] src,
                      input logic [31:0] imm, input logic used, input logic ill,
                      input bit lat);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    bus.InstrF = instr;
    bus.ValidF = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (bus.ReadyD) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.ValidF = 1'b0;
    if (!ok) begin
      n_checks++;
      $display("FAIL send_timeout: instr 0x%08h not accepted, expected accept", instr);
    end else begin
      e.imm = imm; e.used = used; e.ill = ill; e.lat = lat; e.acc = cyc;
      sbq.push_back(e);
      chk("ImmSrcD", {29'd0, bus.ImmSrcD}, {29'd0, src});
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sbq.size() != 0; k++) @(negedge clk);
    if (sbq.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", sbq.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int vcount;
    rst        = 1'b1;
    bus.InstrF = 32'h0000_0000;
    bus.ValidF = 1'b0;
    bus.FlushD = 1'b0;
    bus.ReadyE = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_ValidE", {31'd0, bus.ValidE}, 32'd0);
    chk("rst_ImmExtE", bus.ImmExtE, 32'h0000_0000);
    chk("rst_InstrD", bus.InstrD, 32'h0000_0000);
    chk("rst_IllegalCount", {24'd0, bus.IllegalCount}, 32'd0);
    chk("rst_ReadyD", {31'd0, bus.ReadyD}, 32'd1);
    chk("rst_ImmSrcD", {29'd0, bus.ImmSrcD}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Immediate decode, back-to-back, with latency check
    send(32'hFFF0_0093, 3'b000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    send(32'h0011_2223, 3'b001, 32'h0000_0004, 1'b1, 1'b0, 1'b1);
    send(32'h1234_5037, 3'b100, 32'h1234_5000, 1'b1, 1'b0, 1'b1);
    send(32'h0000_006F, 3'b010, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    drain();

    // Backpressure: A held in execute, B in decode, C refused
    bus.ReadyE = 1'b0;
    send(32'h0010_0093, 3'b000, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    send(32'h0020_0093, 3'b000, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    bus.InstrF = 32'h0030_0093;
    bus.ValidF = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_ReadyD", {31'd0, bus.ReadyD}, 32'd0);
      chk("bp_ValidE", {31'd0, bus.ValidE}, 32'd1);
      chk("bp_ImmExtE", bus.ImmExtE, 32'h0000_0001);
      @(posedge clk);
      #1;
    end
    bus.ReadyE = 1'b1;
    send(32'h0030_0093, 3'b000, 32'h0000_0003, 1'b1, 1'b0, 1'b0);
    drain();

    // Flush: prior decode word still reaches execute, offered word dropped
    send(32'h0640_0093, 3'b000, 32'h0000_0064, 1'b1, 1'b0, 1'b1);
    bus.InstrF = 32'h0050_0113;
    bus.ValidF = 1'b1;
    bus.FlushD = 1'b1;
    @(negedge clk);
    chk("flush_ReadyD", {31'd0, bus.ReadyD}, 32'd1);
    @(posedge clk);
    #1;
    bus.FlushD = 1'b0;
    bus.ValidF = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("flush_ValidE_after", {31'd0, bus.ValidE}, 32'd0);
    @(posedge clk);
    #1;
    drain();

    // R-type and illegal
    send(32'h0020_81B3, 3'b000, 32'h0000_0002, 1'b0, 1'b0, 1'b1);
    send(32'hFFFF_FFFF, 3'b000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);
    drain();
    chk("IllegalCount_1", {24'd0, bus.IllegalCount}, 32'd1);
    for (int k = 0; k < 253; k++) send(32'hFFFF_FFFF, 3'b000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    drain();
    chk("IllegalCount_254", {24'd0, bus.IllegalCount}, 32'd254);
    for (int k = 0; k < 47; k++) send(32'hFFFF_FFFF, 3'b000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    drain();
    chk("IllegalCount_sat", {24'd0, bus.IllegalCount}, 32'd255);

    // Reset mid-stream with both stages full
    bus.ReadyE = 1'b0;
    send(32'h0070_0093, 3'b000, 32'h0000_0007, 1'b1, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 3'b000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    chk("midrst_ReadyD_during", {31'd0, bus.ReadyD}, 32'd1);
    chk("midrst_ImmSrcD_during", {29'd0, bus.ImmSrcD}, 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_ValidE", {31'd0, bus.ValidE}, 32'd0);
    chk("midrst_ImmExtE", bus.ImmExtE, 32'h0000_0000);
    chk("midrst_flags", {30'd0, bus.ImmUsedE, bus.IllegalE}, 32'd0);
    chk("midrst_InstrD", bus.InstrD, 32'h0000_0000);
    chk("midrst_IllegalCount", {24'd0, bus.IllegalCount}, 32'd0);
    chk("midrst_ReadyD", {31'd0, bus.ReadyD}, 32'd1);
    rst = 1'b0;
    bus.ReadyE = 1'b1;
    vcount = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.ValidE) vcount++;
    end
    chk("midrst_no_ValidE", vcount, 32'd0);
    @(posedge clk);
    #1;
    send(32'h0011_2223, 3'b001, 32'h0000_0004, 1'b1, 1'b0, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
